// File: rtl/pwm_rgb_driver.sv
// Three-channel PWM driver for an RGB LED.
// A shared period counter sweeps 0..PWM_INTERVAL-1. Each channel compares it
// against its active duty word and registers the pin. New duty triples land
// in shadow registers through a valid/ready handshake. They move to the active
// registers only at a period boundary, so a period is never torn mid-way.

// One colour channel: it holds the shadow and active duty words and the registered pin.
module pwm_rgb_channel #(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DW           = $clog2(PWM_INTERVAL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  input  logic [DW-1:0] i_cnt,
  input  logic          i_capture,
  input  logic          i_apply,
  input  logic [DW-1:0] i_duty,
  output logic          o_pin
);
  localparam logic [DW-1:0] LP_MAX = DW'(PWM_INTERVAL);
  localparam logic          LP_OFF = ACTIVE_LOW;

  logic [DW-1:0] r_shadow, r_active;
  logic          r_pin;
  logic [DW-1:0] w_clamped;
  logic          w_on;

  // Saturate at capture so the compare never needs to handle oversize words.
  assign w_clamped = (i_duty > LP_MAX) ? LP_MAX : i_duty;
  assign w_on      = (i_cnt < r_active);
  assign o_pin     = r_pin;

  // Shadow takes the offered word. Active takes the shadow when the top says the period allows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else if (i_capture) begin
      r_shadow <= w_clamped;
    end else if (i_apply) begin
      r_active <= r_shadow;
    end
  end

  // The pin is registered, so it lags the counter by one clk. It is forced to the inactive level while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_pin <= LP_OFF;
    else if (!i_enable) r_pin <= LP_OFF;
    else                r_pin <= w_on ^ LP_OFF;
  end
endmodule

// Top: period counter, handshake and period strobe, plus three channel instances.
module pwm_rgb_driver #(
  parameter  int PWM_INTERVAL = 1200,
  parameter  bit ACTIVE_LOW   = 1'b1,
  localparam int DW           = $clog2(PWM_INTERVAL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] duty_r,
  input  logic [DW-1:0] duty_g,
  input  logic [DW-1:0] duty_b,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          red_n,
  output logic          green_n,
  output logic          blue_n,
  output logic          period_start
);
  localparam logic [DW-1:0] LP_LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0]       r_cnt;
  logic                r_pending;
  logic                r_period_start;
  logic                r_en_d;
  logic                w_wrap, w_accept, w_apply;
  logic [2:0][DW-1:0]  w_duty;
  logic [2:0]          w_pin;

  assign w_wrap   = enable && (r_cnt == LP_LAST);
  assign w_accept = duty_valid && !r_pending;
  // Disabled: there is no period to protect, so apply at once.
  assign w_apply  = r_pending && (w_wrap || !enable);

  assign duty_ready   = !r_pending;
  assign period_start = r_period_start;
  assign w_duty       = {duty_r, duty_g, duty_b};
  assign {red_n, green_n, blue_n} = w_pin;

  // The period counter runs while enabled and parks at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_cnt <= '0;
    else if (!enable)   r_cnt <= '0;
    else if (w_wrap)    r_cnt <= '0;
    else                r_cnt <= r_cnt + DW'(1);
  end

  // The pending flag is the single-slot occupancy of the shadow registers.
  // Accept can only fire while the flag is clear, so it never collides with apply.
  // A triple caught on a wrap cycle therefore waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_pending <= 1'b0;
    else if (w_accept) r_pending <= 1'b1;
    else if (w_apply)  r_pending <= 1'b0;
  end

  // One-clk strobe after each wrap, and after enable rises with cnt at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_start <= 1'b0;
      r_en_d         <= 1'b0;
    end else begin
      r_period_start <= enable && (w_wrap || !r_en_d);
      r_en_d         <= enable;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    pwm_rgb_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DW           (DW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (enable),
      .i_cnt     (r_cnt),
      .i_capture (w_accept),
      .i_apply   (w_apply),
      .i_duty    (w_duty[c]),
      .o_pin     (w_pin[c])
    );
  end
endmodule

// File: tb/tb_pwm_rgb_driver.sv
// Bench for pwm_rgb_driver with PWM_INTERVAL=10 and active-low pins.
// A period-level reference tracks the position in the period, the handshake slot and the duty words.
// Directed scenarios also count low cycles per period.
module tb_pwm_rgb_driver;
  localparam int P  = 10;
  localparam int DW = $clog2(P) + 1;

  logic          clk = 1'b0, rst = 1'b0, enable = 1'b0, duty_valid = 1'b0;
  logic [DW-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic          duty_ready, red_n, green_n, blue_n, period_start;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  pwm_rgb_driver #(.PWM_INTERVAL(P), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .red_n(red_n), .green_n(green_n), .blue_n(blue_n),
    .period_start(period_start)
  );

  // Reference state: position in the period, one-slot mailbox and the duty words.
  int m_pos;
  bit m_full;
  int m_next[3];
  int m_cur[3];
  bit m_pin[3];
  bit m_ps;
  bit m_was_on;

  function automatic int clampd(int v);
    return (v > P) ? P : v;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_full = 0; m_ps = 0; m_was_on = 0;
    for (int i = 0; i < 3; i++) begin m_next[i] = 0; m_cur[i] = 0; m_pin[i] = 1; end
  endfunction

  // One clock of the reference, evaluated from the inputs that were stable before the edge.
  function automatic void model_clk();
    bit end_of_period;
    int req[3];
    req[0] = clampd(int'(duty_r)); req[1] = clampd(int'(duty_g)); req[2] = clampd(int'(duty_b));
    end_of_period = enable && (m_pos == P - 1);
    for (int i = 0; i < 3; i++) m_pin[i] = enable ? !(m_pos < m_cur[i]) : 1'b1;
    m_ps = enable && (end_of_period || !m_was_on);
    m_was_on = enable;
    if (duty_valid && !m_full) begin
      m_next = req; m_full = 1;
    end else if (m_full && (end_of_period || !enable)) begin
      m_cur = m_next; m_full = 0;
    end
    m_pos = enable ? (m_pos + 1) % P : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, step the reference and compare every output at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_clk();
    @(negedge clk);
    chk("outputs", {28'd0, red_n, green_n, blue_n, period_start, duty_ready},
        {28'd0, m_pin[0], m_pin[1], m_pin[2], m_ps, !m_full});
  endtask

  // Run n clocks and count low cycles on each pin plus period_start pulses.
  task automatic run_count(input int n, output int lr, output int lg, output int lb, output int nps);
    lr = 0; lg = 0; lb = 0; nps = 0;
    for (int k = 0; k < n; k++) begin
      cyc();
      lr += int'(!red_n); lg += int'(!green_n); lb += int'(!blue_n); nps += int'(period_start);
    end
  endtask

  task automatic wait_ps();
    for (int k = 0; k < 3 * P && !period_start; k++) cyc();
    chk("ps_wait", {31'd0, period_start}, 32'd1);
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < 2 * P && m_pos != p; k++) cyc();
  endtask

  task automatic offer(input int r, input int g, input int b);
    for (int k = 0; k < 3 * P && !duty_ready; k++) cyc();
    chk("ready_wait", {31'd0, duty_ready}, 32'd1);
    duty_r = DW'(r); duty_g = DW'(g); duty_b = DW'(b); duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
  endtask

  int lr, lg, lb, nps;

  initial begin
    model_reset();
    // Reset with no clock edge yet.
    rst = 1'b1;
    #1;
    chk("rst_noclk", {28'd0, red_n, green_n, blue_n, period_start, duty_ready}, 32'b11101);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Load 3/10/0 while disabled, then enable.
    offer(3, 10, 0);
    cyc();
    enable = 1'b1;
    run_count(10, lr, lg, lb, nps);
    chk("p1_red_low", lr, 3); chk("p1_green_low", lg, 10); chk("p1_blue_low", lb, 0);
    run_count(20, lr, lg, lb, nps);
    chk("p23_red_low", lr, 6); chk("p23_green_low", lg, 20); chk("p23_blue_low", lb, 0);
    chk("p23_ps_count", nps, 2);

    // Offer r=7 at cnt=4: ready drops, the current period keeps 3, the next period has 7.
    wait_pos(4);
    duty_r = DW'(7); duty_g = DW'(10); duty_b = DW'(0); duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
    chk("busy_after_accept", {31'd0, duty_ready}, 32'd0);
    wait_ps();
    chk("ready_after_wrap", {31'd0, duty_ready}, 32'd1);
    run_count(10, lr, lg, lb, nps);
    chk("r7_red_low", lr, 7);

    // An oversize word saturates, so red stays on for whole periods.
    offer(15, 0, 0);
    wait_ps();
    run_count(20, lr, lg, lb, nps);
    chk("clamp_red_low", lr, 20); chk("clamp_green_low", lg, 0);

    // A triple accepted on the wrap cycle applies one period late.
    offer(2, 0, 0);
    wait_ps();
    wait_pos(P - 1);
    duty_r = DW'(5); duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
    chk("wrap_accept_busy", {31'd0, duty_ready}, 32'd0);
    run_count(10, lr, lg, lb, nps);
    chk("wrap_next_red_low", lr, 2);
    run_count(10, lr, lg, lb, nps);
    chk("wrap_after_red_low", lr, 5);

    // Mid-period reset with a triple pending discards everything.
    wait_pos(5);
    duty_r = DW'(8); duty_g = DW'(8); duty_b = DW'(8); duty_valid = 1'b1;
    cyc();
    duty_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async", {28'd0, red_n, green_n, blue_n, period_start, duty_ready}, 32'b11101);
    cyc();
    rst = 1'b0;
    run_count(25, lr, lg, lb, nps);
    chk("post_rst_dark", lr + lg + lb, 0);

    // Random traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      duty_r = DW'($urandom_range(0, 31));
      duty_g = DW'($urandom_range(0, 31));
      duty_b = DW'($urandom_range(0, 31));
      duty_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; model_reset(); cyc(); rst = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
